// File: rtl/mem_port_pkg.sv
// Shared types and constants for the multicycle memory access unit.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

  // Counter must hold values up to TIMEOUT-1; sized from TIMEOUT itself.
  function automatic int unsigned timerWidth(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_if.sv
// Request/acknowledge bus between the access unit and variable-latency memory.
interface mem_port_if #(
  parameter int unsigned DW = 32
);
  logic          m_req;
  logic          m_we;
  logic [DW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_wdata, input  m_ack, m_rdata);
  modport slave  (input  m_req, m_we, m_addr, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/mem_port_timer.sv
// Wait-state counter for the BUSY phase; tc flags the last permitted cycle.
module mem_port_timer #(
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)   count <= '0;
    else if (load)    count <= loadVal;
    else if (en)      count <= count + 1'b1;
  end

  // Asserted while the counter would reach TIMEOUT on the coming edge.
  assign tc = (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port.sv
// Memory access unit: address select, req/ack handshake, IR/MDR capture, stall.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          iord,
  input  logic          ir_write,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] mdr,
  output logic          stall,
  output logic          err,
  mem_port_if.master    mem
);
  localparam int unsigned CNT_W = timerWidth(TIMEOUT);

  state_t        state, nextState;
  logic [DW-1:0] selAddr;
  logic [DW-1:0] mAddr, mWdata;
  logic          mWe, irTarget;
  logic          latch, capture, setErr, timerClr, timerEn, tc;

  assign selAddr = iord ? alu_out : pc;

  mem_port_timer #(
    .W       (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timerClr),
    .en      (timerEn),
    .load    (1'b0),
    .loadVal ('0),
    .tc      (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    setErr    = 1'b0;
    timerClr  = 1'b0;
    timerEn   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          stall    = 1'b1;
          latch    = 1'b1;
          timerClr = 1'b1;
          if (selAddr[1:0] != ALIGN_MASK) begin
            setErr    = 1'b1;
            nextState = DONE;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        stall   = 1'b1;
        timerEn = 1'b1;
        // An ack on the timeout edge takes precedence over the abort.
        if (mem.m_ack) begin
          capture   = ~mWe;
          nextState = DONE;
        end else if (tc) begin
          setErr    = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir       <= '0;
      mdr      <= '0;
      err      <= 1'b0;
      mAddr    <= '0;
      mWdata   <= '0;
      mWe      <= 1'b0;
      irTarget <= 1'b0;
    end else begin
      if (latch) begin
        mAddr    <= selAddr;
        mWdata   <= wdata;
        mWe      <= mem_write;
        irTarget <= ir_write;
      end
      if (capture) begin
        if (irTarget) ir  <= mem.m_rdata;
        else          mdr <= mem.m_rdata;
      end
      if (setErr) err <= 1'b1;
    end
  end

  assign mem.m_req   = (state == BUSY);
  assign mem.m_we    = mWe;
  assign mem.m_addr  = mAddr;
  assign mem.m_wdata = mWdata;
endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed table, corner sequences, random accesses.
module tb_mem_port;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, iord = 1'b0, ir_write = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, wdata = '0;
  logic [31:0] ir, mdr;
  logic        stall, err;

  mem_port_if #(.DW(32)) bus ();

  mem_port #(.DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc(pc), .alu_out(alu_out), .wdata(wdata),
    .ir(ir), .mdr(mdr), .stall(stall), .err(err), .mem(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; bus.m_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One controller access: strobes held until the stall releases; memory acks
  // on the delay-th request cycle (never if delay exceeds TO).
  task automatic doAccess(input bit rd, input bit wr, input bit io, input bit irw,
                          input logic [31:0] pcV, input logic [31:0] aluV,
                          input logic [31:0] wdV, input int delay, input logic [31:0] rdv,
                          output int stallCnt, output int reqCnt, output bit busOk);
    logic [31:0] expA;
    bit done;
    stallCnt = 0; reqCnt = 0; busOk = 1'b1;
    expA = io ? aluV : pcV;
    @(negedge clk);
    mem_read = rd; mem_write = wr; iord = io; ir_write = irw;
    pc = pcV; alu_out = aluV; wdata = wdV; bus.m_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (stall) stallCnt++;
      if (bus.m_req) begin
        reqCnt++;
        if (bus.m_addr !== expA || bus.m_we !== wr || bus.m_wdata !== wdV) busOk = 1'b0;
        if (reqCnt == delay) begin
          bus.m_ack = 1'b1;
          bus.m_rdata = rdv;
        end
      end
      done = !stall;
      @(negedge clk);
      bus.m_ack = 1'b0;
      bus.m_rdata = $urandom;
      if (done) break;
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  typedef struct {
    bit rd, wr, io, irw;
    logic [31:0] pcV, aluV, wdV, rdv;
    int delay;
    int expStall, expReq;
    logic [31:0] expIr, expMdr;
    bit expErr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int sc, rc;
    bit bok;
    logic [31:0] mIr, mMdr;
    bit mErr;

    vecs[0] = '{1,0,0,1, 32'h40,  32'h0,   32'h0,       32'h8C22_0004, 1, 2, 1, 32'h8C22_0004, 32'h0,         0};
    vecs[1] = '{1,0,1,0, 32'h0,   32'h100, 32'h0,       32'hDEAD_BEEF, 4, 5, 4, 32'h8C22_0004, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1,1,1,1, 32'h0,   32'h200, 32'h1234_5678, 32'hFFFF_FFFF, 2, 3, 2, 32'h8C22_0004, 32'hDEAD_BEEF, 0};
    vecs[3] = '{1,0,0,0, 32'h300, 32'h0,   32'h0,       32'hA5A5_A5A5, 8, 9, 8, 32'h8C22_0004, 32'hA5A5_A5A5, 0};
    vecs[4] = '{1,0,1,0, 32'h0,   32'h102, 32'h0,       32'h5555_5555, 1, 1, 0, 32'h8C22_0004, 32'hA5A5_A5A5, 1};
    vecs[5] = '{1,0,0,1, 32'h44,  32'h0,   32'h0,       32'h0123_4567, 3, 4, 3, 32'h0123_4567, 32'hA5A5_A5A5, 1};

    bus.m_ack = 1'b0;
    bus.m_rdata = '0;

    doReset();
    #1;
    check("rst ir", ir, 0);
    check("rst mdr", mdr, 0);
    check("rst err", {31'b0, err}, 0);
    check("rst stall", {31'b0, stall}, 0);
    check("rst m_req", {31'b0, bus.m_req}, 0);
    check("rst m_we", {31'b0, bus.m_we}, 0);
    check("rst m_addr", bus.m_addr, 0);
    check("rst m_wdata", bus.m_wdata, 0);

    foreach (vecs[i]) begin
      doAccess(vecs[i].rd, vecs[i].wr, vecs[i].io, vecs[i].irw, vecs[i].pcV, vecs[i].aluV,
               vecs[i].wdV, vecs[i].delay, vecs[i].rdv, sc, rc, bok);
      #1;
      check($sformatf("vec%0d stall", i), sc, vecs[i].expStall);
      check($sformatf("vec%0d req", i), rc, vecs[i].expReq);
      check($sformatf("vec%0d bus", i), {31'b0, bok}, 1);
      check($sformatf("vec%0d ir", i), ir, vecs[i].expIr);
      check($sformatf("vec%0d mdr", i), mdr, vecs[i].expMdr);
      check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].expErr});
    end

    // Timeout with no ack, then a stray ack in IDLE.
    doReset();
    doAccess(1, 0, 1, 0, 32'h0, 32'h400, 32'h0, 100, 32'h0, sc, rc, bok);
    #1;
    check("to stall", sc, TO + 1);
    check("to req", rc, TO);
    check("to err", {31'b0, err}, 1);
    check("to mdr", mdr, 0);
    @(negedge clk);
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray m_req", {31'b0, bus.m_req}, 0);
    check("stray stall", {31'b0, stall}, 0);
    @(negedge clk);
    bus.m_ack = 1'b0;
    #1;
    check("stray ir", ir, 0);
    check("stray mdr", mdr, 0);
    check("stray err", {31'b0, err}, 1);

    // Reset during the second BUSY cycle, followed by a late ack.
    doReset();
    doAccess(1, 0, 0, 1, 32'h10, 32'h0, 32'h0, 1, 32'h1111_2222, sc, rc, bok);
    doAccess(1, 0, 1, 0, 32'h0, 32'h20, 32'h0, 1, 32'h3333_4444, sc, rc, bok);
    #1;
    check("pre ir", ir, 32'h1111_2222);
    check("pre mdr", mdr, 32'h3333_4444);
    @(negedge clk);
    mem_read = 1'b1; iord = 1'b0; ir_write = 1'b1; pc = 32'h80;
    @(negedge clk);
    #1;
    check("mid busy1 m_req", {31'b0, bus.m_req}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    #1;
    check("mid m_req", {31'b0, bus.m_req}, 0);
    check("mid stall", {31'b0, stall}, 0);
    check("mid ir", ir, 0);
    check("mid mdr", mdr, 0);
    bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.m_ack = 1'b0;
    #1;
    check("late ir", ir, 0);
    check("late mdr", mdr, 0);
    check("late m_req", {31'b0, bus.m_req}, 0);

    // Random accesses against a transaction-level model.
    mIr = '0; mMdr = '0; mErr = 1'b0;
    doReset();
    for (int n = 0; n < 60; n++) begin
      bit rd, wr, io, irw, mis;
      logic [31:0] pcV, aluV, wdV, rdv, a;
      int delay, eStall, eReq;
      if (n % 15 == 14) begin
        doReset();
        mIr = '0; mMdr = '0; mErr = 1'b0;
      end
      wr = $urandom_range(0, 2) == 0;
      rd = wr ? bit'($urandom_range(0, 1)) : 1'b1;
      io = $urandom_range(0, 1);
      irw = $urandom_range(0, 1);
      pcV = $urandom & 32'hFFFF_FFFC;
      aluV = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) pcV = pcV | $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) aluV = aluV | $urandom_range(1, 3);
      wdV = $urandom;
      rdv = $urandom;
      delay = $urandom_range(1, 11);
      a = io ? aluV : pcV;
      mis = (a % 4) != 0;
      if (mis) begin
        eStall = 1; eReq = 0; mErr = 1'b1;
      end else if (delay <= TO) begin
        eStall = delay + 1; eReq = delay;
        if (!wr) begin
          if (irw) mIr = rdv;
          else     mMdr = rdv;
        end
      end else begin
        eStall = TO + 1; eReq = TO; mErr = 1'b1;
      end
      doAccess(rd, wr, io, irw, pcV, aluV, wdV, delay, rdv, sc, rc, bok);
      #1;
      check($sformatf("rnd%0d stall", n), sc, eStall);
      check($sformatf("rnd%0d req", n), rc, eReq);
      check($sformatf("rnd%0d bus", n), {31'b0, bok}, 1);
      check($sformatf("rnd%0d ir", n), ir, mIr);
      check($sformatf("rnd%0d mdr", n), mdr, mMdr);
      check($sformatf("rnd%0d err", n), {31'b0, err}, {31'b0, mErr});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Memory access unit directly downstream of the multicycle controller FSM.
- Consumes the controller's MemRead, MemWrite, IorD and IRWrite strobes.
- Selects the address from PC or ALUOut and runs a req/ack handshake to a variable-latency memory.
- Latches the returned word into the instruction register (IR) or the memory data register (MDR), and drives `stall`, which clock-enables the controller state register and the datapath until the access completes.

Parameters:
- `DW`, 32, data and address width.
- `TIMEOUT`, 255, maximum cycles in BUSY without `m_ack` before the access is aborted; range 1 to 2^16-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_read`  in  1  controller MemRead.
- `mem_write`  in  1  controller MemWrite.
- `iord`  in  1  address select: 0 = `pc`, 1 = `alu_out`.
- `ir_write`  in  1  route read data to `ir` (else to `mdr`).
- `pc`  in  DW  program counter.
- `alu_out`  in  DW  ALUOut register (load/store effective address).
- `wdata`  in  DW  B register, the store data.
- `ir`  out  DW  instruction register.
- `mdr`  out  DW  memory data register.
- `stall`  out  1  hold controller and datapath this cycle.
- `err`  out  1  sticky error flag (misaligned address or timeout).
- `m_req`  out  1  memory request.
- `m_we`  out  1  memory write enable, valid with `m_req`.
- `m_addr`  out  DW  memory word address, valid with `m_req`.
- `m_wdata`  out  DW  store data, valid with `m_req`.
- `m_ack`  in  1  memory completion, single-cycle pulse.
- `m_rdata`  in  DW  read data, valid with `m_ack`.

Behaviour:
- Reset: synchronous on `rst`=1 at a `clk` edge.
  - State returns to IDLE; timeout counter cleared.
  - `ir`=0, `mdr`=0, `err`=0, `m_req`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, `stall`=0.
  - Reset mid-access abandons the access; a later `m_ack` is ignored.
- States: IDLE, BUSY, DONE (2-bit encoding, value 3 unused and recovers to IDLE).
- IDLE, when `mem_read | mem_write`:
  - `stall`=1, combinational in the same cycle.
  - Latch addr = `iord` ? `alu_out` : `pc`, `m_wdata` <= `wdata`, `m_we` <= `mem_write` (write has priority when both are high), and the `ir_write` target.
  - If addr[1:0] != 0: set `err`, issue no request, go to DONE.
  - Otherwise go to BUSY.
- IDLE with neither strobe: `stall`=0, no action.
- BUSY:
  - `m_req`=1 and `stall`=1; `m_addr`, `m_we`, `m_wdata` are held stable.
  - The counter increments each cycle.
  - On `m_ack`:
    - For reads, capture `m_rdata` into `ir` if the latched target is set, else into `mdr`.
    - For writes, capture nothing.
    - Drop `m_req` next cycle and go to DONE.
  - If the counter reaches `TIMEOUT` with no `m_ack`: set `err`, drop `m_req`, leave `ir`/`mdr` unchanged, go to DONE.
  - An `m_ack` arriving on the same edge as the timeout wins: data is captured and `err` is not set.
- DONE:
  - `stall`=0, so the controller advances at the end of this cycle.
  - Strobes still high in this cycle are ignored, so no re-trigger.
  - Next state is IDLE.
- Latency:
  - Minimum access (ack in the first BUSY cycle) is 3 cycles: IDLE-request, BUSY, DONE.
  - `stall` is high for 2 cycles plus the number of extra wait cycles.
- `m_ack` outside BUSY is ignored.
- `ir` and `mdr` change only on an accepted `m_ack` or on reset.
- `err` stays set until `rst`.

Decomposition:
- Package `mem_port_pkg`:
  - State encoding constants IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Width of the timeout counter, derived from `TIMEOUT`.
  - Alignment mask 2'b00.
- One natural sub-module, `mem_port_timer`: loadable counter with clear, enable and a terminal-count output.

Test Plan:
- Reset then fetch: `rst` pulse; `mem_read`=1, `ir_write`=1, `iord`=0, `pc`=0x0000_0040; memory acks on the 1st BUSY cycle with 0x8C22_0004 -> `m_addr`=0x40, `m_we`=0, `stall` high exactly 2 cycles, `ir`=0x8C22_0004, `mdr`=0.
- Load with wait states: `iord`=1, `alu_out`=0x100, `ir_write`=0; ack after 4 BUSY cycles with 0xDEAD_BEEF -> `stall` high 5 cycles, `mdr`=0xDEAD_BEEF, `ir` unchanged.
- Store with both strobes high: `mem_read`=1, `mem_write`=1, `iord`=1, `alu_out`=0x200, `wdata`=0x1234_5678 -> `m_we`=1, `m_wdata`=0x1234_5678, `ir`/`mdr` unchanged after ack.
- Misaligned address: `alu_out`=0x102 with `mem_read` -> `m_req` never asserted, `stall` high 1 cycle, `err`=1 and stays 1.
- Timeout: `TIMEOUT`=8, no ack -> `m_req` high 8 cycles then 0, `err`=1; a stray `m_ack` afterwards is ignored.
- Reset mid-access: `rst` during the 2nd BUSY cycle -> next cycle state IDLE, `m_req`=0, `stall`=0, `ir`=0, `mdr`=0; a late `m_ack` is ignored.
